// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction ROM and loads the IF/ID register.
// Handles stall, redirect and a sticky HALT state on misaligned redirect targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        halted,
  output logic [31:0] fetch_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic        halted_q, halted_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        target_aligned;

  assign target_aligned = (redirect_target[1:0] == 2'b00);

  // Redirect beats stall beats advance; HALT freezes everything until reset.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    if_valid_d  = if_valid_q;
    halted_d    = halted_q;
    fetch_cnt_d = fetch_cnt_q;

    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          if_pc_d    = 32'h0000_0000;
          if_instr_d = NOP_INSTR;
          if_valid_d = 1'b0;
          if (target_aligned) begin
            pc_d = redirect_target;
          end else begin
            state_d  = HALT;
            halted_d = 1'b1;
          end
        end else if (!stall) begin
          if_pc_d     = pc_q;
          if_instr_d  = rom_instr;
          if_valid_d  = 1'b1;
          pc_d        = pc_q + 32'd4;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
      end
      HALT: begin
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
        halted_d   = 1'b1;
      end
      default: begin
        state_d  = HALT;
        halted_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      if_pc_q     <= 32'h0000_0000;
      if_instr_q  <= NOP_INSTR;
      if_valid_q  <= 1'b0;
      halted_q    <= 1'b0;
      fetch_cnt_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      if_valid_q  <= if_valid_d;
      halted_q    <= halted_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign rom_addr  = pc_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign if_valid  = if_valid_q;
  assign halted    = halted_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-002 SHALL provide parameter NOP_INSTR, default 32'h0000_0013: instruction word inserted on bubbles and flushes.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port stall  input  1: downstream stage cannot accept a new instruction this cycle.
REQ-006 SHALL have port redirect_valid  input  1: branch or jump taken; load the PC from redirect_target.
REQ-007 SHALL have port redirect_target  input  32: byte address of the redirect destination.
REQ-008 SHALL have port rom_addr  output  32: byte address presented to the instruction memory.
REQ-009 SHALL have port rom_instr  input  32: little-endian instruction word returned combinationally for rom_addr.
REQ-010 SHALL have port if_pc  output  32: PC of the instruction held in the IF/ID register.
REQ-011 SHALL have port if_instr  output  32: instruction held in the IF/ID register.
REQ-012 SHALL have port if_valid  output  1: if_instr is a real fetched instruction, not a bubble.
REQ-013 SHALL have port halted  output  1: high while in state HALT.
REQ-014 SHALL have port fetch_cnt  output  32: number of instructions loaded into IF/ID since reset.

Function
REQ-015 SHALL hold an internal 32-bit register pc and drive rom_addr = pc combinationally, with zero added latency.
REQ-016 SHALL implement two states: RUN (entered from reset) and HALT.
REQ-017 In RUN, each edge SHALL apply exactly one of the following rules, in priority order: redirect, stall, advance.
REQ-018 Redirect applies when redirect_valid=1 and redirect_target[1:0]=2'b00:
  - pc <= redirect_target
  - if_valid <= 0, if_instr <= NOP_INSTR, if_pc <= 0 (flush the wrong-path instruction)
  - fetch_cnt unchanged
REQ-019 Redirect SHALL take priority over stall when both are asserted in the same cycle.
REQ-020 Misaligned redirect applies when redirect_valid=1 and redirect_target[1:0]!=2'b00:
  - state <= HALT
  - pc unchanged
  - IF/ID flushed as in REQ-018
REQ-021 Stall applies when stall=1 and redirect_valid=0: pc, if_pc, if_instr, if_valid and fetch_cnt all hold.
REQ-022 Advance applies otherwise:
  - if_pc <= pc, if_instr <= rom_instr, if_valid <= 1
  - pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000)
  - fetch_cnt <= fetch_cnt + 1, modulo 2^32
REQ-023 In HALT:
  - pc holds
  - if_valid = 0, if_instr = NOP_INSTR
  - stall and redirect_valid are ignored
  - exit from HALT only via reset
REQ-024 halted SHALL be registered and equal 1 exactly while state = HALT.
REQ-025 The first instruction (address RESET_PC) SHALL appear on if_instr with if_valid=1 after the first non-stalled edge following reset deassertion.
REQ-026 Instruction content SHALL pass through unmodified; no decode of rom_instr.

Reset
REQ-027 On rst_n=0, the block SHALL immediately, without waiting for a clock edge, set:
  - state = RUN, pc = RESET_PC
  - if_pc = 0, if_instr = NOP_INSTR, if_valid = 0
  - halted = 0, fetch_cnt = 0
REQ-028 Reset asserted mid-stall, mid-redirect or in HALT SHALL discard all in-flight state, with no partial update on the edge where rst_n rises.

Verification
REQ-029 Scenario: reset release, ROM[0..8] = 32'hff600293, 32'h00528333, 32'h406283b3, three edges -> if_pc sequence 0,4,8; if_instr matches the ROM words in order; fetch_cnt = 3; rom_addr = 12.
REQ-030 Scenario: stall held for 3 cycles at pc = 8 -> if_pc = 4 and if_instr = 32'h00528333 stable for 3 edges; rom_addr stays 8; fetch_cnt unchanged.
REQ-031 Scenario: redirect_valid=1 with redirect_target = 32'h40 and stall=1 in the same cycle -> next edge gives if_valid = 0, if_instr = 32'h00000013, rom_addr = 32'h40; the following edge loads if_pc = 32'h40.
REQ-032 Scenario: redirect_target = 32'h42 -> halted = 1, if_valid = 0 held for 10 cycles regardless of stall/redirect; rst_n pulse returns pc to 0 and halted to 0.
REQ-033 Scenario: pc forced to 32'hFFFF_FFFC via redirect, one advance -> if_pc = 32'hFFFF_FFFC, rom_addr = 0.
REQ-034 Scenario: rst_n asserted between clock edges while if_valid = 1 -> all outputs take reset values before the next edge.
